kmeans_ctrl_gen2: RTL and testbench



---
 rtl/kmeans_ctrl_gen2.sv | 192 +++++++++++++++++++
 tb/tb_kmeans_ctrl_gen2.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_ctrl_gen2.sv
// Second-generation k-means sequencer: centroid load, point streaming, mean recalc, convergence loop, write-back.
// Optional iteration limit (max_iter / timeout) is enabled by defining KMEANS_ITER_LIMIT_EN.
module kmeans_ctrl_gen2 #(
  parameter int CENT_NUM      = 8,
  parameter int LOG2_CENT_NUM = 3,
  parameter int ADDR_W        = 9,
  parameter int PIPE_DEPTH    = 3,
  parameter int REG_NUM_W     = 4,
  parameter int RES_BASE      = 8,
  parameter int ITER_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic [ADDR_W-1:0]        first_addr,
  input  logic [ADDR_W-1:0]        last_addr,
  input  logic [ITER_W-1:0]        max_iter,
  output logic [REG_NUM_W-1:0]     reg_num,
  output logic                     reg_rd,
  output logic                     reg_wr,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_rd_en,
  output logic [CENT_NUM-1:0]      cent_load_en,
  output logic                     pipe_clr_n,
  output logic                     accum_en,
  output logic                     div_en,
  output logic [LOG2_CENT_NUM-1:0] cent_cnt,
  output logic                     cnvrg_reg_en,
  output logic                     cnvrg_clr,
  input  logic                     cnvrg_valid,
  input  logic                     converged,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [ITER_W-1:0]        iter_cnt,
  output logic [3:0]               state_dbg
);

  localparam int CNT_MAX = (CENT_NUM > PIPE_DEPTH) ? CENT_NUM : PIPE_DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FIRST, S_FILL, S_STREAM, S_DRAIN, S_CALC, S_CHECK, S_WB, S_FIN
  } state_t;

  state_t              state, nxt_state;
  logic [CNT_W-1:0]    cnt, nxt_cnt;
  logic [ADDR_W-1:0]   first_q, last_q;
  logic                exh;
  logic [PIPE_DEPTH-1:0] rd_hist;
  logic [PIPE_DEPTH:0]   rd_line;
  logic                iter_hit;
  logic                unused_rd_top;

  // rd_line[j] is ram_rd_en as issued j cycles ago; a point reaches the accumulator PIPE_DEPTH cycles after issue.
  assign rd_line       = {rd_hist, ram_rd_en};
  assign unused_rd_top = rd_line[PIPE_DEPTH];
  assign state_dbg     = state;

`ifdef KMEANS_ITER_LIMIT_EN
  assign iter_hit = (max_iter != '0) &&
                    (({1'b0, iter_cnt} + (ITER_W+1)'(1)) == {1'b0, max_iter});
`else
  logic unused_max_iter;
  assign unused_max_iter = ^max_iter;
  assign iter_hit        = 1'b0;
  assign timeout         = 1'b0;
`endif

  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:   if (go && (last_addr >= first_addr)) nxt_state = S_LOAD;
      S_LOAD:   if (cnt == CNT_W'(CENT_NUM)) nxt_state = S_FIRST;
      S_FIRST:  if (PIPE_DEPTH > 1) nxt_state = S_FILL;
                else nxt_state = exh ? S_DRAIN : S_STREAM;
      S_FILL:   if (cnt == CNT_W'(PIPE_DEPTH - 1)) nxt_state = exh ? S_DRAIN : S_STREAM;
      S_STREAM: if (exh) nxt_state = S_DRAIN;
      S_DRAIN:  if (cnt == CNT_W'(PIPE_DEPTH)) nxt_state = S_CALC;
      S_CALC:   if (cnt == CNT_W'(CENT_NUM - 1)) nxt_state = S_CHECK;
      S_CHECK:  if (cnvrg_valid) nxt_state = (converged || iter_hit) ? S_WB : S_FIRST;
      S_WB:     if (cnt == CNT_W'(CENT_NUM - 1)) nxt_state = S_FIN;
      S_FIN:    nxt_state = S_IDLE;
      default:  nxt_state = S_IDLE;
    endcase

    nxt_cnt = '0;
    if (nxt_state != state)
      nxt_cnt = (nxt_state == S_FILL || nxt_state == S_DRAIN) ? CNT_W'(1) : '0;
    else if (state inside {S_LOAD, S_FILL, S_DRAIN, S_CALC, S_WB})
      nxt_cnt = cnt + CNT_W'(1);
  end

  // Outputs are registered from the next state so each one lines up with the cycle of that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      first_q      <= '0;
      last_q       <= '0;
      exh          <= 1'b0;
      rd_hist      <= '0;
      reg_num      <= '0;
      reg_rd       <= 1'b0;
      reg_wr       <= 1'b0;
      ram_addr     <= '0;
      ram_rd_en    <= 1'b0;
      cent_load_en <= '0;
      pipe_clr_n   <= 1'b0;
      accum_en     <= 1'b0;
      div_en       <= 1'b0;
      cent_cnt     <= '0;
      cnvrg_reg_en <= 1'b0;
      cnvrg_clr    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      iter_cnt     <= '0;
`ifdef KMEANS_ITER_LIMIT_EN
      timeout      <= 1'b0;
`endif
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      rd_hist      <= rd_line[PIPE_DEPTH-1:0];
      reg_num      <= '0;
      reg_rd       <= 1'b0;
      reg_wr       <= 1'b0;
      ram_rd_en    <= 1'b0;
      cent_load_en <= '0;
      div_en       <= 1'b0;
      cent_cnt     <= '0;
      cnvrg_reg_en <= 1'b0;
      cnvrg_clr    <= 1'b0;
      done         <= 1'b0;
      busy         <= !(nxt_state == S_IDLE || nxt_state == S_FIN);
      pipe_clr_n   <= nxt_state inside {S_FILL, S_STREAM, S_DRAIN, S_CALC, S_CHECK};
      accum_en     <= (nxt_state inside {S_STREAM, S_DRAIN}) && rd_line[PIPE_DEPTH-1];

      if (state == S_IDLE && nxt_state == S_LOAD) begin
        first_q  <= first_addr;
        last_q   <= last_addr;
        iter_cnt <= '0;
`ifdef KMEANS_ITER_LIMIT_EN
        timeout  <= 1'b0;
`endif
      end
      if (state == S_CHECK && nxt_state == S_FIRST && iter_cnt != '1)
        iter_cnt <= iter_cnt + ITER_W'(1);
`ifdef KMEANS_ITER_LIMIT_EN
      if (state == S_CHECK && nxt_state == S_WB && !converged)
        timeout <= 1'b1;
`endif

      case (nxt_state)
        S_LOAD: begin
          // Register-file data lags the read by one cycle, so the load strobe trails reg_rd.
          reg_rd <= nxt_cnt < CNT_W'(CENT_NUM);
          if (nxt_cnt < CNT_W'(CENT_NUM)) reg_num <= REG_NUM_W'(nxt_cnt);
          if (nxt_cnt != '0) cent_load_en <= CENT_NUM'(1) << (nxt_cnt - CNT_W'(1));
        end
        S_FIRST: begin
          ram_addr  <= first_q;
          ram_rd_en <= 1'b1;
          exh       <= (first_q == last_q);
          cnvrg_clr <= 1'b1;
        end
        S_FILL, S_STREAM: begin
          // Never step past last_addr, so the top of the address space cannot wrap.
          if (!exh) begin
            ram_addr  <= ram_addr + ADDR_W'(1);
            ram_rd_en <= 1'b1;
            exh       <= ((ram_addr + ADDR_W'(1)) == last_q);
          end
        end
        S_CALC: begin
          div_en       <= 1'b1;
          cent_cnt     <= LOG2_CENT_NUM'(nxt_cnt);
          cent_load_en <= CENT_NUM'(1) << nxt_cnt;
          cnvrg_reg_en <= 1'b1;
        end
        S_WB: begin
          reg_wr   <= 1'b1;
          reg_num  <= REG_NUM_W'(RES_BASE) + REG_NUM_W'(nxt_cnt);
          cent_cnt <= LOG2_CENT_NUM'(nxt_cnt);
        end
        S_FIN: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_ctrl_gen2.sv
// Scoreboard bench for kmeans_ctrl_gen2: directed runs push expected events, a negedge monitor pops and compares.
module tb_kmeans_ctrl_gen2;
  localparam int CN = 8, LG = 3, AW = 9, PD = 3, RW = 4, RB = 8, IW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           go = 1'b0;
  logic [AW-1:0]  first_addr = '0, last_addr = '0;
  logic [IW-1:0]  max_iter = '0;
  logic [RW-1:0]  reg_num;
  logic           reg_rd, reg_wr;
  logic [AW-1:0]  ram_addr;
  logic           ram_rd_en;
  logic [CN-1:0]  cent_load_en;
  logic           pipe_clr_n, accum_en, div_en;
  logic [LG-1:0]  cent_cnt;
  logic           cnvrg_reg_en, cnvrg_clr;
  logic           cnvrg_valid = 1'b0, converged = 1'b0;
  logic           busy, done, timeout;
  logic [IW-1:0]  iter_cnt;
  logic [3:0]     state_dbg;

  kmeans_ctrl_gen2 #(.CENT_NUM(CN), .LOG2_CENT_NUM(LG), .ADDR_W(AW), .PIPE_DEPTH(PD),
                     .REG_NUM_W(RW), .RES_BASE(RB), .ITER_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .first_addr(first_addr), .last_addr(last_addr),
    .max_iter(max_iter), .reg_num(reg_num), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .cent_load_en(cent_load_en),
    .pipe_clr_n(pipe_clr_n), .accum_en(accum_en), .div_en(div_en), .cent_cnt(cent_cnt),
    .cnvrg_reg_en(cnvrg_reg_en), .cnvrg_clr(cnvrg_clr), .cnvrg_valid(cnvrg_valid),
    .converged(converged), .busy(busy), .done(done), .timeout(timeout),
    .iter_cnt(iter_cnt), .state_dbg(state_dbg)
  );

  // scoreboard
  int n_cmp = 0, n_err = 0;
  logic [63:0] exp_rd_q[$], exp_wr_q[$], exp_load_q[$], exp_addr_q[$], exp_cnt_q[$], exp_done_q[$];
  logic conv_q[$];
  logic mon_en = 1'b0, spur_en = 1'b0;
  int accum_n = 0, clr_n = 0;
  int resp_timer = 0;
  logic resp_prev_ren = 1'b0, resp_spur = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event, value 0x%0h, nothing expected", nm, act);
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({reg_num, reg_rd, reg_wr, ram_addr, ram_rd_en, cent_load_en, pipe_clr_n,
                accum_en, div_en, cent_cnt, cnvrg_reg_en, cnvrg_clr, busy, done,
                timeout, iter_cnt, state_dbg});
  endfunction

  // monitor
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (reg_rd) begin
        if (exp_rd_q.size() == 0) unexp("reg_rd", 64'(reg_num));
        else chk("reg_rd_num", 64'(reg_num), exp_rd_q.pop_front());
      end
      if (reg_wr) begin
        if (exp_wr_q.size() == 0) unexp("reg_wr", 64'(reg_num));
        else chk("reg_wr_num", 64'(reg_num), exp_wr_q.pop_front());
      end
      if (cent_load_en != '0) begin
        if (exp_load_q.size() == 0) unexp("cent_load_en", 64'(cent_load_en));
        else chk("cent_load_en", 64'(cent_load_en), exp_load_q.pop_front());
      end
      if (ram_rd_en) begin
        if (exp_addr_q.size() == 0) unexp("ram_addr", 64'(ram_addr));
        else chk("ram_addr", 64'(ram_addr), exp_addr_q.pop_front());
      end
      if (div_en || reg_wr) begin
        if (exp_cnt_q.size() == 0) unexp("cent_cnt", 64'(cent_cnt));
        else chk("cent_cnt", 64'(cent_cnt), exp_cnt_q.pop_front());
      end
      if (accum_en) accum_n++;
      if (cnvrg_clr) clr_n++;
      if (done) begin
        if (exp_done_q.size() == 0) unexp("done", 64'(iter_cnt));
        else chk("done_busy_to_iter_accum_clr",
                 64'({busy, timeout, iter_cnt, 16'(accum_n), 8'(clr_n)}), exp_done_q.pop_front());
        accum_n = 0;
        clr_n   = 0;
      end
    end
  end

  // convergence-block responder, plus a stray valid/converged pulse right after FIRST
  initial forever begin
    @(negedge clk);
    resp_spur = spur_en && cnvrg_clr;
    if (resp_prev_ren && !cnvrg_reg_en) resp_timer = 2;
    resp_prev_ren = cnvrg_reg_en;
    @(posedge clk);
    #1;
    cnvrg_valid = 1'b0;
    converged   = 1'b0;
    if (resp_spur) begin
      cnvrg_valid = 1'b1;
      converged   = 1'b1;
    end else if (resp_timer == 1) begin
      cnvrg_valid = 1'b1;
      converged   = (conv_q.size() > 0) ? conv_q.pop_front() : 1'b0;
      resp_timer  = 0;
    end else if (resp_timer > 1) begin
      resp_timer--;
    end
  end

  // driver tasks
  task automatic pulse_go(input int f, input int l);
    @(posedge clk); #1;
    first_addr = AW'(f);
    last_addr  = AW'(l);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic run(input int f, input int l, input int passes, input logic to,
                     input int mx, input logic mid_go);
    int   n = l - f + 1;
    logic got_done = 1'b0;
    max_iter = IW'(mx);
    if (!to) begin
      for (int p = 0; p < passes - 1; p++) conv_q.push_back(1'b0);
      conv_q.push_back(1'b1);
    end
    for (int k = 0; k < CN; k++) begin
      exp_rd_q.push_back(64'(k));
      exp_load_q.push_back(64'(1) << k);
    end
    for (int p = 0; p < passes; p++) begin
      for (int a = f; a <= l; a++) exp_addr_q.push_back(64'(a));
      for (int k = 0; k < CN; k++) begin
        exp_load_q.push_back(64'(1) << k);
        exp_cnt_q.push_back(64'(k));
      end
    end
    for (int k = 0; k < CN; k++) begin
      exp_wr_q.push_back(64'(RB + k));
      exp_cnt_q.push_back(64'(k));
    end
    exp_done_q.push_back(64'({1'b0, to, IW'(passes - 1), 16'(passes * n), 8'(passes)}));
    pulse_go(f, l);
    @(negedge clk);
    chk("busy_after_go", 64'(busy), 64'(1));
    if (mid_go) pulse_go(0, 3);
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    chk("done_seen", 64'(got_done), 64'(1));
    @(negedge clk);
    chk("idle_after_done", 64'({busy, state_dbg}), 64'(0));
  endtask

  task automatic reset_and_check(input string nm);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk({nm, "_async"}, outs_vec(), 64'(0));
    @(negedge clk);
    chk({nm, "_held"}, outs_vec(), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen_done, seen_wr, seen_busy, clr_cnt;
    logic got_acc;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs_vec(), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 64'({busy, state_dbg}), 64'(0));
    mon_en  = 1'b1;
    spur_en = 1'b1;

    run('h10, 'h13, 1, 1'b0, 0, 1'b0);
    run('h05, 'h05, 1, 1'b0, 0, 1'b0);
    run('h20, 'h23, 3, 1'b0, 0, 1'b0);
    run('h1FE, 'h1FF, 1, 1'b0, 0, 1'b1);

    pulse_go('h20, 'h10);
    @(negedge clk);
    chk("invalid_go_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    chk("invalid_go_state", 64'({busy, state_dbg}), 64'(0));

`ifdef KMEANS_ITER_LIMIT_EN
    run('h30, 'h31, 3, 1'b1, 3, 1'b0);
    run('h30, 'h31, 1, 1'b0, 3, 1'b0);
`else
    mon_en = 1'b0;
    max_iter = IW'(3);
    seen_done = 0;
    clr_cnt = 0;
    pulse_go('h00, 'h40);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done) seen_done++;
      if (cnvrg_clr) clr_cnt++;
    end
    chk("no_exit_done", 64'(seen_done), 64'(0));
    chk("no_exit_passes_ge4", 64'(clr_cnt >= 4), 64'(1));
    reset_and_check("reset_no_exit");
`endif

    mon_en = 1'b0;
    got_acc = 1'b0;
    pulse_go('h00, 'h40);
    for (int i = 0; i < 200 && !got_acc; i++) begin
      @(negedge clk);
      if (accum_en) got_acc = 1'b1;
    end
    chk("stream_reached", 64'(got_acc), 64'(1));
    repeat (5) @(negedge clk);
    reset_and_check("reset_mid_stream");
    seen_wr = 0;
    seen_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (reg_wr) seen_wr++;
      if (busy) seen_busy++;
    end
    chk("no_wb_after_reset", 64'({16'(seen_wr), 16'(seen_busy), state_dbg}), 64'(0));

    mon_en = 1'b1;
    run('h00, 'h01, 1, 1'b0, 0, 1'b0);

    repeat (4) @(negedge clk);
    chk("queues_drained", 64'(exp_rd_q.size() + exp_wr_q.size() + exp_load_q.size() +
                              exp_addr_q.size() + exp_cnt_q.size() + exp_done_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
